// File: rtl/regfile_spill_fill.sv
// Context save/restore engine for the 8-entry register file (R1..R4, S1..S4).
// Spill streams masked registers out; fill writes streamed words into masked registers.
module regfile_spill_fill #(
    parameter logic [2:0] LOAD_CODE = 3'b010,
    parameter logic [2:0] HOLD_CODE = 3'b010
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_dir,
    input  logic [7:0]  i_mask,
    output logic        o_busy,
    output logic        o_done,
    input  logic [31:0] i_rf_outa,
    output logic [2:0]  o_rf_outa_sel,
    output logic [31:0] o_rf_i,
    output logic [2:0]  o_rf_fun_sel,
    output logic [3:0]  o_rf_reg_sel,
    output logic [3:0]  o_rf_scr_sel,
    output logic [31:0] o_dout,
    output logic        o_dout_valid,
    input  logic        i_dout_ready,
    input  logic [31:0] i_din,
    input  logic        i_din_valid,
    output logic        o_din_ready
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SP_RD  = 3'd1;
    localparam logic [2:0] S_SP_OUT = 3'd2;
    localparam logic [2:0] S_FL_IN  = 3'd3;
    localparam logic [2:0] S_FL_WR  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]  r_state;
    logic [7:0]  r_pend;
    logic [31:0] r_dout;
    logic [31:0] r_rf_i;
    logic        r_dout_valid;

    logic [2:0]  w_idx;
    logic [7:0]  w_onehot;
    logic [7:0]  w_pend_clr;
    logic [3:0]  w_reg_sel;
    logic [3:0]  w_scr_sel;
    logic        w_wr;

    // Lowest pending index first, so registers are visited R1 -> S4.
    always_comb begin
        w_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_idx = 3'(i);
            end
        end
    end

    assign w_onehot   = 8'd1 << w_idx;
    assign w_pend_clr = r_pend & ~w_onehot;
    assign w_wr       = (r_state == S_FL_WR);

    // Enable vectors are bit-reversed: bit 3 selects the first register of each bank.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sel
            assign w_reg_sel[3-gi] = w_onehot[gi];
            assign w_scr_sel[3-gi] = w_onehot[4+gi];
        end
    endgenerate

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_pend       <= 8'd0;
            r_dout       <= 32'd0;
            r_rf_i       <= 32'd0;
            r_dout_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_pend <= i_mask;
                        if (i_mask == 8'd0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= i_dir ? S_FL_IN : S_SP_RD;
                        end
                    end
                end
                S_SP_RD: begin
                    r_dout       <= i_rf_outa;
                    r_dout_valid <= 1'b1;
                    r_state      <= S_SP_OUT;
                end
                S_SP_OUT: begin
                    if (i_dout_ready) begin
                        r_dout_valid <= 1'b0;
                        r_pend       <= w_pend_clr;
                        r_state      <= (w_pend_clr != 8'd0) ? S_SP_RD : S_DONE;
                    end
                end
                S_FL_IN: begin
                    if (i_din_valid) begin
                        r_rf_i  <= i_din;
                        r_state <= S_FL_WR;
                    end
                end
                S_FL_WR: begin
                    r_pend  <= w_pend_clr;
                    r_state <= (w_pend_clr != 8'd0) ? S_FL_IN : S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy        = (r_state == S_SP_RD) || (r_state == S_SP_OUT) ||
                           (r_state == S_FL_IN) || (r_state == S_FL_WR);
    assign o_done        = (r_state == S_DONE);
    assign o_din_ready   = (r_state == S_FL_IN);
    assign o_dout        = r_dout;
    assign o_dout_valid  = r_dout_valid;
    assign o_rf_i        = r_rf_i;
    assign o_rf_outa_sel = w_idx;
    assign o_rf_fun_sel  = w_wr ? LOAD_CODE : HOLD_CODE;
    assign o_rf_reg_sel  = w_wr ? w_reg_sel : 4'd0;
    assign o_rf_scr_sel  = w_wr ? w_scr_sel : 4'd0;

endmodule

// File: tb/tb_regfile_spill_fill.sv
// Randomized bench for regfile_spill_fill: a register-file model answers OutA reads and
// applies writes, while a mask-driven reference predicts spilled words and filled registers.
module tb_regfile_spill_fill;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic [7:0]  mask = 8'd0;
    logic        busy, done;
    logic [31:0] rf_outa;
    logic [2:0]  outa_sel;
    logic [31:0] rf_i;
    logic [2:0]  fun_sel;
    logic [3:0]  reg_sel, scr_sel;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic [31:0] din = 32'd0;
    logic        din_valid = 1'b0;
    logic        din_ready;

    always #5 clk = ~clk;

    regfile_spill_fill dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_start       (start),
        .i_dir         (dir),
        .i_mask        (mask),
        .o_busy        (busy),
        .o_done        (done),
        .i_rf_outa     (rf_outa),
        .o_rf_outa_sel (outa_sel),
        .o_rf_i        (rf_i),
        .o_rf_fun_sel  (fun_sel),
        .o_rf_reg_sel  (reg_sel),
        .o_rf_scr_sel  (scr_sel),
        .o_dout        (dout),
        .o_dout_valid  (dout_valid),
        .i_dout_ready  (dout_ready),
        .i_din         (din),
        .i_din_valid   (din_valid),
        .o_din_ready   (din_ready)
    );

    logic [31:0] rf [8];
    logic [31:0] exp_rf [8];
    assign rf_outa = rf[outa_sel];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int s_cyc, done_cyc, first_v;
    int n_done, n_vcyc, n_rcyc, n_ecyc, n_bad, n_unstable, n_busy;
    bit din_taken, stall_prev;
    logic [31:0] stall_dat;
    logic [31:0] got_w[$];
    logic [31:0] exp_w[$];
    logic [31:0] fill_dat[$];
    int          wr_i[$];
    logic [31:0] wr_d[$];
    int          exp_i[$];
    logic [31:0] exp_d[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic clear_stats();
        n_done = 0; n_vcyc = 0; n_rcyc = 0; n_ecyc = 0; n_bad = 0; n_unstable = 0; n_busy = 0;
        first_v = -1; done_cyc = -1; stall_prev = 1'b0; din_taken = 1'b0;
        got_w.delete(); wr_i.delete(); wr_d.delete();
    endtask

    // Observes the settled outputs of the current cycle; writes land at the following edge.
    task automatic sample();
        logic [7:0] en;
        int idx;
        din_taken = din_ready && din_valid;
        if (busy) n_busy++;
        if (dout_valid) begin
            n_vcyc++;
            if (first_v < 0) first_v = cyc;
        end
        if (dout_valid && dout_ready) got_w.push_back(dout);
        if (stall_prev && dout_valid && dout !== stall_dat) n_unstable++;
        stall_prev = dout_valid && !dout_ready;
        stall_dat  = dout;
        if (din_ready) n_rcyc++;
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        en = {reg_sel, scr_sel};
        if (en != 8'd0) begin
            n_ecyc++;
            if ($countones(en) != 1 || fun_sel != 3'b010) n_bad++;
            idx = 0;
            for (int k = 0; k < 4; k++) begin
                if (reg_sel[3-k]) idx = k;
                if (scr_sel[3-k]) idx = k + 4;
            end
            wr_i.push_back(idx);
            wr_d.push_back(rf_i);
            rf[idx] = rf_i;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_op(input bit d, input logic [7:0] m, input int mode,
                          input bit extra, input bit seq_data);
        int ptr, n;
        clear_stats();
        exp_w.delete(); exp_i.delete(); exp_d.delete(); fill_dat.delete();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                if (d) begin
                    fill_dat.push_back(seq_data ? 32'hA0 + 32'(n) : $urandom);
                    exp_i.push_back(i);
                    exp_d.push_back(fill_dat[n]);
                end else begin
                    exp_w.push_back(exp_rf[i]);
                end
                n++;
            end
        end
        ptr = 0;
        start = 1'b1; dir = d; mask = m; s_cyc = cyc;
        for (int t = 0; t < 300 && n_done == 0; t++) begin
            if (t > 0) begin
                start = extra && (t == 3);
                dir   = 1'($urandom);
                mask  = 8'($urandom);
            end
            case (mode)
                0: begin dout_ready = 1'b1; din_valid = d && (ptr < n); end
                1: begin dout_ready = cyc[0]; din_valid = d && (ptr < n) && cyc[0]; end
                default: begin
                    dout_ready = 1'($urandom_range(0, 1));
                    din_valid  = d && (ptr < n) && ($urandom_range(0, 2) != 0);
                end
            endcase
            din = (ptr < n && d) ? fill_dat[ptr] : 32'($urandom);
            tick();
            if (din_taken) ptr++;
        end
        start = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
        tick();
        chk("done_pulses", n_done, 1);
        chk("busy_cycles", n_busy, done_cyc - s_cyc - 1);
        chk("bad_enables", n_bad, 0);
        if (!d) begin
            chk("spill_count", got_w.size(), exp_w.size());
            for (int k = 0; k < exp_w.size() && k < got_w.size(); k++)
                chk($sformatf("spill_word%0d", k), got_w[k], exp_w[k]);
            chk("spill_stable", n_unstable, 0);
            chk("spill_din_ready", n_rcyc, 0);
            chk("spill_enables", n_ecyc, 0);
        end else begin
            for (int k = 0; k < exp_i.size(); k++) exp_rf[exp_i[k]] = exp_d[k];
            chk("fill_count", wr_i.size(), exp_i.size());
            for (int k = 0; k < exp_i.size() && k < wr_i.size(); k++) begin
                chk($sformatf("fill_idx%0d", k), wr_i[k], exp_i[k]);
                chk($sformatf("fill_dat%0d", k), wr_d[k], exp_d[k]);
            end
            chk("fill_dout_valid", n_vcyc, 0);
        end
        for (int k = 0; k < 8; k++) chk($sformatf("rf%0d", k), rf[k], exp_rf[k]);
    endtask

    initial begin
        bit found;
        for (int k = 0; k < 8; k++) begin
            rf[k]     = 32'h11111111 * (k + 1);
            exp_rf[k] = 32'h11111111 * (k + 1);
        end
        clear_stats();
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_din_ready", din_ready, 0);
        chk("rst_enables", {reg_sel, scr_sel}, 0);
        chk("rst_funsel", fun_sel, 3'b010);
        chk("rst_dout", dout, 0);
        chk("rst_rf_i", rf_i, 0);
        rst = 1'b0;
        tick();

        run_op(1'b0, 8'hFF, 0, 1'b0, 1'b0);
        chk("spill_first_valid_lat", first_v - s_cyc, 2);
        chk("spill_done_lat", done_cyc - s_cyc, 17);

        run_op(1'b0, 8'b1000_0100, 1, 1'b0, 1'b0);
        run_op(1'b1, 8'h0F, 0, 1'b0, 1'b1);
        chk("fill_enable_cycles", n_ecyc, 4);
        run_op(1'b1, 8'h90, 2, 1'b0, 1'b0);
        chk("gap_enable_cycles", n_ecyc, 2);

        run_op(1'b0, 8'h00, 0, 1'b0, 1'b0);
        chk("zero_done_lat", done_cyc - s_cyc, 1);
        chk("zero_dout_valid", n_vcyc, 0);
        run_op(1'b1, 8'h00, 0, 1'b0, 1'b0);
        chk("zero_fill_din_ready", n_rcyc, 0);
        chk("zero_fill_enables", n_ecyc, 0);

        // Reset while a fill write is being presented.
        clear_stats();
        start = 1'b1; dir = 1'b1; mask = 8'hFF; din = 32'hDEAD0000; din_valid = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            tick();
            start = 1'b0;
            din = 32'hDEAD0000 + 32'(t);
            if ({reg_sel, scr_sel} != 8'd0) found = 1'b1;
        end
        chk("rst_fl_wr_reached", found, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_enables", {reg_sel, scr_sel}, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_din_ready", din_ready, 0);
        din_valid = 1'b0;
        n_done = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_mid_no_done", n_done, 0);
        chk("rst_mid_idle", busy, 0);
        for (int k = 0; k < 8; k++) exp_rf[k] = rf[k];

        run_op(1'b0, 8'b0110_1001, 2, 1'b1, 1'b0);
        run_op(1'b1, 8'b1010_0110, 2, 1'b1, 1'b0);

        for (int r = 0; r < 8; r++)
            run_op(1'($urandom), 8'($urandom), 2, 1'($urandom), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
